// File: rtl/sat_mac_if.sv
// Stream interface for sat_mac: operand-pair input channel and result output channel.
//   in_valid/in_ready : operand pair handshake, in_a/in_b signed W-bit operands
//   out_valid/out_ready : result handshake, out_data saturated sum, out_sat sticky flag
// master = producer/consumer side (testbench or upstream), slave = the MAC itself.
interface sat_mac_if #(
  parameter int unsigned W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sat;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sat_mac.sv
// Saturating signed fixed-point multiply-accumulate. Sums TERMS products of Q(W-F).F
// operands and presents one clamped W-bit result per group; every intermediate step
// clamps instead of wrapping.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, highest priority
//   clear : synchronous abort of the current group (discards any held result)
//   bus   : sat_mac_if slave modport (in_valid/in_ready/in_a/in_b,
//           out_valid/out_ready/out_data/out_sat)
module sat_mac #(
  parameter int unsigned W     = 16,
  parameter int unsigned F     = 8,
  parameter int unsigned TERMS = 8
) (
  input logic      clk,
  input logic      reset,
  input logic      clear,
  sat_mac_if.slave bus
);

  localparam int unsigned CntW = $clog2(TERMS + 1);
  localparam logic signed [W-1:0] MaxVal = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StAcc, StDrain, StHold} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     count_q, count_d;
  logic signed [W-1:0] p_reg_q, p_reg_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic                p_vld_q, p_vld_d;
  logic                sat_q, sat_d;

  logic                  accept;
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] prod_shift;
  logic                  prod_clamp;
  logic signed [W-1:0]   prod_sat;
  logic signed [W:0]     sum;
  logic                  sum_clamp;
  logic signed [W-1:0]   sum_sat;

  assign accept = bus.in_valid && (state_q == StAcc);

  // Product path: full-width multiply, floor shift, clamp to W bits.
  always_comb begin
    prod       = (2*W)'($signed(bus.in_a)) * (2*W)'($signed(bus.in_b));
    prod_shift = prod >>> F;
    // Fits in W bits only when the top W+1 bits are all copies of the sign.
    prod_clamp = !((&prod_shift[2*W-1:W-1]) || (~|prod_shift[2*W-1:W-1]));
    if (prod_clamp) begin
      prod_sat = prod_shift[2*W-1] ? MinVal : MaxVal;
    end else begin
      prod_sat = prod_shift[W-1:0];
    end
  end

  // Accumulate path: W+1-bit sum, overflow when the two top bits disagree.
  always_comb begin
    sum       = (W+1)'(acc_q) + (W+1)'(p_reg_q);
    sum_clamp = sum[W] ^ sum[W-1];
    if (sum_clamp) begin
      sum_sat = sum[W] ? MinVal : MaxVal;
    end else begin
      sum_sat = sum[W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_reg_d = p_reg_q;
    p_vld_d = accept;
    acc_d   = acc_q;
    sat_d   = sat_q;

    if (accept) begin
      p_reg_d = prod_sat;
      count_d = count_q + CntW'(1);
      if (prod_clamp) sat_d = 1'b1;
    end

    if (p_vld_q) begin
      acc_d = sum_sat;
      if (sum_clamp) sat_d = 1'b1;
    end

    unique case (state_q)
      StAcc: begin
        if (accept && (count_q == CntW'(TERMS - 1))) state_d = StDrain;
      end
      StDrain: state_d = StHold;
      StHold: begin
        if (bus.out_ready) begin
          state_d = StAcc;
          acc_d   = '0;
          sat_d   = 1'b0;
          count_d = '0;
        end
      end
      default: state_d = StAcc;
    endcase

    if (clear) begin
      state_d = StAcc;
      acc_d   = '0;
      count_d = '0;
      p_vld_d = 1'b0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StAcc;
      count_q <= '0;
      p_reg_q <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_reg_q <= p_reg_d;
      p_vld_q <= p_vld_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_data  = acc_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_sat_mac.sv
// Self-checking bench for sat_mac: directed groups from the test plan plus randomized
// groups, compared against an arithmetic reference model of the saturating dot product.
module tb_sat_mac;
  localparam int unsigned W     = 16;
  localparam int unsigned F     = 8;
  localparam int unsigned TERMS = 8;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  always #5 clk = ~clk;

  sat_mac_if #(.W(W)) bus ();

  sat_mac #(
    .W    (W),
    .F    (F),
    .TERMS(TERMS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] ga[TERMS];
  logic [W-1:0] gb[TERMS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: floor-scaled products, each clamped, summed with a clamp after every add.
  function automatic void model(output logic [W-1:0] d, output logic s);
    longint acc, p, q;
    longint hi, lo;
    hi  = 32767;
    lo  = -32768;
    acc = 0;
    s   = 1'b0;
    for (int i = 0; i < TERMS; i++) begin
      p = longint'($signed(ga[i])) * longint'($signed(gb[i]));
      q = p / 256;
      if (p < 0 && (p % 256) != 0) q = q - 1;
      if (q > hi) begin q = hi; s = 1'b1; end
      else if (q < lo) begin q = lo; s = 1'b1; end
      acc = acc + q;
      if (acc > hi) begin acc = hi; s = 1'b1; end
      else if (acc < lo) begin acc = lo; s = 1'b1; end
    end
    d = acc[W-1:0];
  endfunction

  task automatic fill(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < TERMS; i++) begin
      ga[i] = a;
      gb[i] = b;
    end
  endtask

  // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps.
  // use_reset: abort the held result with reset instead of the out_ready handshake.
  task automatic run_group(input string name, input int gap_mode, input int hold_cycles,
                           input bit use_reset);
    int           idx;
    int           guard;
    logic         drive;
    logic [W-1:0] exp_d;
    logic         exp_s;
    idx   = 0;
    guard = 0;
    model(exp_d, exp_s);
    while (idx < TERMS && guard < 400) begin
      @(negedge clk);
      guard++;
      case (gap_mode)
        0:       drive = 1'b1;
        1:       drive = (guard % 2) == 1;
        default: drive = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = drive;
      bus.in_a     = drive ? ga[idx] : W'($urandom);
      bus.in_b     = drive ? gb[idx] : W'($urandom);
      if (drive && bus.in_ready) idx++;
    end
    if (idx < TERMS) begin
      check($sformatf("%s accept_timeout", name), 32'(idx), 32'(TERMS));
      bus.in_valid = 1'b0;
      return;
    end
    // One cycle after the last accept: draining, junk pair must be refused.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h7fff;
    bus.in_b     = 16'h7fff;
    check($sformatf("%s drain_out_valid", name), 32'(bus.out_valid), 32'd0);
    check($sformatf("%s drain_in_ready", name), 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check($sformatf("%s out_valid", name), 32'(bus.out_valid), 32'd1);
    check($sformatf("%s out_data", name), 32'(bus.out_data), 32'(exp_d));
    check($sformatf("%s out_sat", name), 32'(bus.out_sat), 32'(exp_s));
    for (int h = 0; h < hold_cycles; h++) begin
      bus.out_ready = 1'b0;
      @(negedge clk);
      check($sformatf("%s hold%0d out_valid", name, h), 32'(bus.out_valid), 32'd1);
      check($sformatf("%s hold%0d in_ready", name, h), 32'(bus.in_ready), 32'd0);
      check($sformatf("%s hold%0d out_data", name, h), 32'(bus.out_data), 32'(exp_d));
    end
    bus.in_valid = 1'b0;
    if (use_reset) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check($sformatf("%s rst out_valid", name), 32'(bus.out_valid), 32'd0);
      check($sformatf("%s rst out_data", name), 32'(bus.out_data), 32'd0);
      check($sformatf("%s rst in_ready", name), 32'(bus.in_ready), 32'd1);
    end else begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check($sformatf("%s post out_valid", name), 32'(bus.out_valid), 32'd0);
      check($sformatf("%s post in_ready", name), 32'(bus.in_ready), 32'd1);
      check($sformatf("%s post acc", name), 32'(bus.out_data), 32'd0);
      check($sformatf("%s post sat", name), 32'(bus.out_sat), 32'd0);
    end
  endtask

  initial begin
    reset         = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data", 32'(bus.out_data), 32'd0);
    check("reset out_sat", 32'(bus.out_sat), 32'd0);
    reset = 1'b0;

    fill(16'h0100, 16'h0200);
    run_group("basic", 0, 0, 1'b0);
    fill(16'h7fff, 16'h7fff);
    run_group("pos_sat", 0, 0, 1'b0);
    fill(16'h8000, 16'h0100);
    run_group("neg_sat", 0, 1, 1'b0);
    fill(16'hffff, 16'h0080);
    run_group("floor", 0, 0, 1'b0);
    fill(16'h0100, 16'h0100);
    run_group("gaps", 1, 5, 1'b0);
    run_group("after_hold", 0, 0, 1'b0);

    // Clear after three accepted terms, with a clamping pair presented alongside.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h7000;
      bus.in_b     = 16'h7000;
    end
    @(negedge clk);
    clear = 1'b1;
    bus.in_a = 16'h7fff;
    bus.in_b = 16'h7fff;
    @(negedge clk);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clear out_data", 32'(bus.out_data), 32'd0);
    check("clear out_sat", 32'(bus.out_sat), 32'd0);
    check("clear in_ready", 32'(bus.in_ready), 32'd1);
    fill(16'h0100, 16'h0100);
    run_group("after_clear", 0, 0, 1'b0);

    fill(16'h0300, 16'h0100);
    run_group("reset_hold", 0, 2, 1'b1);

    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < TERMS; i++) begin
        if (g % 2 == 0) begin
          ga[i] = W'($urandom);
          gb[i] = W'($urandom);
        end else begin
          ga[i] = W'($urandom_range(0, 2047)) - 16'd1024;
          gb[i] = W'($urandom_range(0, 2047)) - 16'd1024;
        end
      end
      run_group($sformatf("rand%0d", g), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
